// File: rtl/pl_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, carrying a control field and a payload field.
// Latency: 1 cycle in to out; sustains 1 entry/cycle while out_ready_i stays high.
// Backpressure: in_ready_o is decoded from the state flop only (low only when both entries are held).
// Optional statistics counters are enabled by defining PL_STAGE_STATS_EN.
module pl_stage_skid #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CTRL_WIDTH-1:0] out_ctrl_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  // One pipeline entry: control bits are cleared to form bubbles, payload bits are left alone.
  typedef struct packed {
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // EMPTY: nothing held. BUSY: main holds an entry. FULL: main and skid both hold entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  assign in_entry = {in_ctrl_i, in_data_i};

  // Next-state and register-load decode; flush overrides every handshake outcome.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Kill both entries; payload bits hold to avoid toggling the wide datapath.
      state_d     = ST_EMPTY;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid_i) begin
            main_d  = in_entry;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_valid_i && out_ready_i) begin
            main_d = in_entry;
          end else if (in_valid_i) begin
            // Downstream stalled while upstream still had a ready=1 view: park it in skid.
            skid_d  = in_entry;
            state_d = ST_FULL;
          end else if (out_ready_i) begin
            main_d.ctrl = '0;
            state_d     = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready_o is low here, so no input can arrive; only the pop matters.
          if (out_ready_i) begin
            main_d      = skid_q;
            skid_d.ctrl = '0;
            state_d     = ST_BUSY;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_d.ctrl = '0;
          skid_d.ctrl = '0;
        end
      endcase
    end
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_ctrl_o  = main_q.ctrl;
  assign out_data_o  = main_q.data;

`ifdef PL_STAGE_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  // Saturating counters: stalls with an entry presented, and flushes that killed something.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (flush_i && (state_q != ST_EMPTY) && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pl_stage_skid.sv
// Directed and randomized bench for pl_stage_skid.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Statistics checks depend on whether PL_STAGE_STATS_EN is defined.
module tb_pl_stage_skid;

  localparam int CW = 8;
  localparam int DW = 16;
  localparam int NW = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pl_stage_skid #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl), .out_data_o(out_data),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

`ifdef PL_STAGE_STATS_EN
  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_stall_cnt, s_flush_cnt;

  pl_stage_skid #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_ctrl_o(s_out_ctrl), .out_data_o(s_out_data),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1; in_ctrl = c; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 16'h1234; out_ready = 1'b0;
    rst_n = 1'b1; flush = 1'b0;
    step();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", out_ctrl); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_ctrl = 8'(i + 1); in_data = 16'(16'hA0 + i);
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_ctrl !== 8'(i + 1)) begin errors++; $display("FAIL stream_ctrl[%0d] got %h exp %h", i, out_ctrl, 8'(i + 1)); end
      checks++; if (out_data !== 16'(16'hA0 + i)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, 16'(16'hA0 + i)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL stream_end_ctrl got %h exp 00", out_ctrl); end
    checks++; if (out_data !== 16'h00A7) begin errors++; $display("FAIL stream_end_data got %h exp 00a7", out_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    push(8'h11, 16'h00B1);
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'h11) begin errors++; $display("FAIL bp_first got %b/%h exp 1/11", out_valid, out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    push(8'h22, 16'h00B2);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    checks++; if (out_ctrl !== 8'h11) begin errors++; $display("FAIL bp_full_ctrl got %h exp 11", out_ctrl); end
    step();
    checks++; if (in_ready !== 1'b0 || out_ctrl !== 8'h11 || out_data !== 16'h00B1) begin errors++; $display("FAIL bp_hold got %b/%h/%h exp 0/11/00b1", in_ready, out_ctrl, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'h22 || out_data !== 16'h00B2) begin errors++; $display("FAIL bp_pop2 got %b/%h/%h exp 1/22/00b2", out_valid, out_ctrl, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin errors++; $display("FAIL bp_drain got %b/%h exp 0/00", out_valid, out_ctrl); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    push(8'h44, 16'h00C1);
    push(8'h55, 16'h00C2);
    in_valid = 1'b1; in_ctrl = 8'h33; in_data = 16'h00C3; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl got %h exp 00", out_ctrl); end
    checks++; if (out_data !== 16'h00C1) begin errors++; $display("FAIL flush_data got %h exp 00c1", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_ctrl === 8'h33 || out_ctrl === 8'h55) begin errors++; $display("FAIL flush_ghost[%0d] got %b/%h exp 0/00", i, out_valid, out_ctrl); end
    end
    // flush coinciding with an out-transfer still empties the stage
    push(8'h66, 16'h00C4);
    in_valid = 1'b1; in_ctrl = 8'h77; in_data = 16'h00C5; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 16'h00C4) begin errors++; $display("FAIL flush_xfer got %b/%h/%h exp 0/00/00c4", out_valid, out_ctrl, out_data); end
  endtask

  task automatic test_reset_full();
    do_reset();
    out_ready = 1'b0;
    push(8'h81, 16'h00D1);
    push(8'h82, 16'h00D2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin errors++; $display("FAIL rstfull got %b/%h/%b exp 0/0000/1", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin errors++; $display("FAIL rstfull_after got %b/%h exp 0/00", out_valid, out_ctrl); end
  endtask

  task automatic test_random();
    logic [CW+DW-1:0] q[$];
    logic [CW+DW-1:0] exp_e;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      in_ctrl   = 8'($urandom);
      in_data   = 16'($urandom);
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d got %b exp %b", n, out_valid, q.size() != 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d got %b exp %b", n, in_ready, q.size() < 2); end
      if (out_valid !== 1'b1) begin
        checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL rnd_bubble@%0d got %h exp 00", n, out_ctrl); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_dup@%0d got %h%h exp none", n, out_ctrl, out_data);
        end else begin
          exp_e = q.pop_front();
          checks++; if ({out_ctrl, out_data} !== exp_e) begin errors++; $display("FAIL rnd_data@%0d got %h%h exp %h", n, out_ctrl, out_data, exp_e); end
        end
      end
      if (in_valid && in_ready === 1'b1) q.push_back({in_ctrl, in_data});
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (out_valid === 1'b1 && q.size() != 0) begin
        exp_e = q.pop_front();
        checks++; if ({out_ctrl, out_data} !== exp_e) begin errors++; $display("FAIL rnd_drain got %h%h exp %h", out_ctrl, out_data, exp_e); end
      end
      step();
    end
    checks++; if (q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rnd_loss got left=%0d valid=%b exp 0/0", q.size(), out_valid); end
  endtask

  task automatic test_stats();
    do_reset();
    out_ready = 1'b0;
    push(8'h91, 16'h00E1);
    for (int i = 0; i < 5; i++) step();
`ifdef PL_STAGE_STATS_EN
    checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stats_stall got %0d exp 5", stall_cnt); end
    checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("FAIL stats_sat got %0d exp 3", s_stall_cnt); end
    out_ready = 1'b1; flush = 1'b1;
    step();
    checks++; if (stall_cnt !== 16'd5 || flush_cnt !== 16'd1) begin errors++; $display("FAIL stats_flush got %0d/%0d exp 5/1", stall_cnt, flush_cnt); end
    step();
    flush = 1'b0;
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL stats_flush_empty got %0d exp 1", flush_cnt); end
    out_ready = 1'b0;
    push(8'h92, 16'h00E2);
    for (int i = 0; i < 6; i++) step();
    checks++; if (s_stall_cnt !== 2'd3 || stall_cnt !== 16'd11) begin errors++; $display("FAIL stats_sat6 got %0d/%0d exp 3/11", s_stall_cnt, stall_cnt); end
`else
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL stats_off got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_full();
    test_random();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
